// File: rtl/mmv_input_packer.sv
// rtl/mmv_input_packer.sv - packs MMV consecutive input beats into one wide word
// with frame tracking, zero padding of a short final word and tlast.
module mmv_input_packer #(
   parameter int SIMD         = 1,
   parameter int IP_PRECISION = 8,
   parameter int MMV          = 2,
   parameter int IFMChannels  = 2,
   parameter int IFMWidth     = 8,
   parameter int IFMHeight    = 8
) (
   input  logic                             clk,
   input  logic                             resetn,
   input  logic [SIMD*IP_PRECISION-1:0]     ip_axis_tdata,
   input  logic                             ip_axis_tvalid,
   output logic                             ip_axis_tready,
   output logic [MMV*SIMD*IP_PRECISION-1:0] op_axis_tdata,
   output logic                             op_axis_tvalid,
   input  logic                             op_axis_tready,
   output logic                             op_axis_tlast
);

   localparam int BW           = SIMD * IP_PRECISION;
   localparam int OW           = MMV * BW;
   localparam int EFF_CHANNELS = IFMChannels / SIMD;
   localparam int FRAME_BEATS  = IFMHeight * IFMWidth * EFF_CHANNELS;
   localparam int LANE_W       = (MMV > 1) ? $clog2(MMV) : 1;
   localparam int BEAT_W       = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
   // With MMV==1 there is nothing to accumulate; keep a dummy lane that stays zero.
   localparam int ACC_W        = (MMV > 1) ? (MMV - 1) * BW : BW;

   localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(MMV - 1);
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(FRAME_BEATS - 1);

   logic [LANE_W-1:0] lane_cnt_q, lane_cnt_d;
   logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [OW-1:0]     tdata_q, tdata_d;
   logic              tvalid_q, tvalid_d;
   logic              tlast_q, tlast_d;

   logic              last_beat;
   logic              completing;
   logic              accept;
   logic              drain;
   logic [OW-1:0]     packed_word;

   assign last_beat      = (beat_cnt_q == BEAT_LAST);
   assign completing     = (lane_cnt_q == LANE_LAST) || last_beat;
   assign ip_axis_tready = !completing || !tvalid_q || op_axis_tready;
   assign accept         = ip_axis_tvalid && ip_axis_tready;
   assign drain          = tvalid_q && op_axis_tready;

   assign op_axis_tdata  = tdata_q;
   assign op_axis_tvalid = tvalid_q;
   assign op_axis_tlast  = tlast_q;

   // Lanes above the current one are already zero in acc, which gives the padding.
   always_comb begin
      packed_word = OW'(acc_q);
      packed_word[int'(lane_cnt_q) * BW +: BW] = ip_axis_tdata;
   end

   always_comb begin
      lane_cnt_d = lane_cnt_q;
      beat_cnt_d = beat_cnt_q;
      acc_d      = acc_q;
      tdata_d    = tdata_q;
      tvalid_d   = tvalid_q;
      tlast_d    = tlast_q;

      if (drain) begin
         tvalid_d = 1'b0;
         tlast_d  = 1'b0;
      end

      if (accept) begin
         if (completing) begin
            tdata_d    = packed_word;
            tvalid_d   = 1'b1;
            tlast_d    = last_beat;
            acc_d      = '0;
            lane_cnt_d = '0;
            beat_cnt_d = last_beat ? '0 : beat_cnt_q + 1'b1;
         end else begin
            acc_d[int'(lane_cnt_q) * BW +: BW] = ip_axis_tdata;
            lane_cnt_d = lane_cnt_q + 1'b1;
            beat_cnt_d = beat_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lane_cnt_q <= '0;
         beat_cnt_q <= '0;
         acc_q      <= '0;
         tdata_q    <= '0;
         tvalid_q   <= 1'b0;
         tlast_q    <= 1'b0;
      end else begin
         lane_cnt_q <= lane_cnt_d;
         beat_cnt_q <= beat_cnt_d;
         acc_q      <= acc_d;
         tdata_q    <= tdata_d;
         tvalid_q   <= tvalid_d;
         tlast_q    <= tlast_d;
      end
   end

endmodule

// File: tb/tb_mmv_input_packer.sv
// tb/tb_mmv_input_packer.sv - randomized scoreboard bench for mmv_input_packer
// against a queue-based packing model.
module tb_mmv_input_packer;

   localparam int SIMD = 2;
   localparam int IPP  = 8;
   localparam int MMV  = 4;
   localparam int CH   = 2;
   localparam int FW   = 5;
   localparam int FH   = 2;
   localparam int BW   = SIMD * IPP;
   localparam int OW   = MMV * BW;
   localparam int FB   = FH * FW * (CH / SIMD);

   typedef struct {
      logic [OW-1:0] d;
      logic          l;
   } word_t;

   logic          clk;
   logic          resetn;
   logic [BW-1:0] ip_axis_tdata;
   logic          ip_axis_tvalid;
   logic          ip_axis_tready;
   logic [OW-1:0] op_axis_tdata;
   logic          op_axis_tvalid;
   logic          op_axis_tready;
   logic          op_axis_tlast;

   mmv_input_packer #(
      .SIMD(SIMD), .IP_PRECISION(IPP), .MMV(MMV),
      .IFMChannels(CH), .IFMWidth(FW), .IFMHeight(FH)
   ) dut (
      .clk(clk), .resetn(resetn),
      .ip_axis_tdata(ip_axis_tdata), .ip_axis_tvalid(ip_axis_tvalid),
      .ip_axis_tready(ip_axis_tready),
      .op_axis_tdata(op_axis_tdata), .op_axis_tvalid(op_axis_tvalid),
      .op_axis_tready(op_axis_tready), .op_axis_tlast(op_axis_tlast)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int npass  = 0;
   int ntotal = 0;
   int tlast_seen = 0;
   logic [BW-1:0] next_data = '0;

   // Model state: beats gathered for the word in progress, position in the
   // frame, words produced but not yet drained, and every word ever produced.
   logic [BW-1:0] cur[$];
   int            mb = 0;
   word_t         exp_q[$];
   word_t         log_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      ntotal++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      bit    comp;
      bit    eready;
      bit    drn;
      bit    acc;
      word_t w;
      if (!resetn) begin
         chk("rst_tvalid", 64'(op_axis_tvalid), 64'd0);
         chk("rst_tlast", 64'(op_axis_tlast), 64'd0);
         chk("rst_tdata", op_axis_tdata, 64'd0);
         chk("rst_tready", 64'(ip_axis_tready), 64'd1);
         cur.delete();
         exp_q.delete();
         mb = 0;
      end else begin
         comp   = (cur.size() == MMV - 1) || (mb == FB - 1);
         eready = !comp || (exp_q.size() == 0) || op_axis_tready;
         chk("ip_tready", 64'(ip_axis_tready), 64'(eready));
         chk("op_tvalid", 64'(op_axis_tvalid), 64'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            chk("op_tdata", op_axis_tdata, exp_q[0].d);
            chk("op_tlast", 64'(op_axis_tlast), 64'(exp_q[0].l));
         end
         if (op_axis_tvalid && op_axis_tready && op_axis_tlast) tlast_seen++;
         drn = (exp_q.size() != 0) && op_axis_tready;
         acc = ip_axis_tvalid && eready;
         if (drn) void'(exp_q.pop_front());
         if (acc) begin
            cur.push_back(ip_axis_tdata);
            if (comp) begin
               w.d = '0;
               foreach (cur[i]) w.d[i*BW +: BW] = cur[i];
               w.l = (mb == FB - 1);
               exp_q.push_back(w);
               log_q.push_back(w);
               cur.delete();
               mb = w.l ? 0 : mb + 1;
            end else begin
               mb++;
            end
         end
      end
   end

   task automatic stream(input int nbeats, input int vpct, input int rpct, output int cycles);
      int sent;
      bit took;
      sent   = 0;
      cycles = 0;
      while (sent < nbeats && cycles < 2000) begin
         if (!ip_axis_tvalid && ($urandom_range(99) < vpct)) begin
            ip_axis_tvalid = 1'b1;
            ip_axis_tdata  = next_data;
            next_data++;
         end
         op_axis_tready = ($urandom_range(99) < rpct);
         @(negedge clk);
         took = ip_axis_tvalid && ip_axis_tready;
         @(posedge clk);
         #1;
         cycles++;
         if (took) begin
            ip_axis_tvalid = 1'b0;
            sent++;
         end
      end
      chk("stream_done", 64'(sent), 64'(nbeats));
   endtask

   task automatic idle(input int n);
      ip_axis_tvalid = 1'b0;
      op_axis_tready = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int cyc;
      int base;
      int tl0;
      resetn         = 1'b0;
      ip_axis_tvalid = 1'b0;
      ip_axis_tdata  = '0;
      op_axis_tready = 1'b1;
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;

      // Two back-to-back frames at full rate.
      base = log_q.size();
      next_data = 16'd0;
      stream(2 * FB, 100, 100, cyc);
      chk("basic_cycles", 64'(cyc), 64'(2 * FB));
      idle(3);
      chk("basic_nwords", 64'(log_q.size() - base), 64'd6);
      chk("basic_w0", log_q[base].d, 64'h0003_0002_0001_0000);
      chk("basic_w1_last", 64'(log_q[base+1].l), 64'd0);
      chk("basic_w2", log_q[base+2].d, 64'h0000_0000_0009_0008);
      chk("basic_w2_last", 64'(log_q[base+2].l), 64'd1);
      chk("basic_w3", log_q[base+3].d, 64'h000d_000c_000b_000a);
      chk("basic_w5", log_q[base+5].d, 64'h0000_0000_0013_0012);

      // Back-pressure: first word held, next completing beat must stall.
      base = log_q.size();
      stream(7, 100, 0, cyc);
      ip_axis_tvalid = 1'b1;
      ip_axis_tdata  = next_data;
      next_data++;
      op_axis_tready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("bp_stall_ready", 64'(ip_axis_tready), 64'd0);
         chk("bp_hold_data", op_axis_tdata, 64'h0017_0016_0015_0014);
         @(posedge clk);
         #1;
      end
      stream(3, 100, 100, cyc);
      idle(3);
      chk("bp_w1", log_q[base+1].d, 64'h001b_001a_0019_0018);
      chk("bp_w2", log_q[base+2].d, 64'h0000_0000_001d_001c);
      chk("bp_w2_last", 64'(log_q[base+2].l), 64'd1);

      // Random handshakes over three frames.
      tl0 = tlast_seen;
      stream(3 * FB, 50, 50, cyc);
      idle(4);
      chk("rand_tlast_cnt", 64'(tlast_seen - tl0), 64'd3);

      // Reset mid-frame with a word held at the output.
      stream(6, 100, 0, cyc);
      @(posedge clk);
      #3 resetn = 1'b0;
      #1;
      chk("async_tvalid", 64'(op_axis_tvalid), 64'd0);
      chk("async_tdata", op_axis_tdata, 64'd0);
      chk("async_tlast", 64'(op_axis_tlast), 64'd0);
      chk("async_tready", 64'(ip_axis_tready), 64'd1);
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      base = log_q.size();
      tl0  = tlast_seen;
      next_data = 16'h0100;
      stream(FB, 100, 100, cyc);
      idle(3);
      chk("post_rst_w0", log_q[base].d, 64'h0103_0102_0101_0100);
      chk("post_rst_w2", log_q[base+2].d, 64'h0000_0000_0109_0108);
      chk("post_rst_tlast", 64'(tlast_seen - tl0), 64'd1);

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule

// File: doc/mmv_input_packer.md
# mmv_input_packer

Width-converting input stage that gathers `MMV` consecutive `SIMD*IP_PRECISION` beats from the upstream activation stream into one `MMV*SIMD*IP_PRECISION` word. It feeds the `ip_axis_*` port of the MMV input sliding-window unit directly. It tracks frame boundaries, zero-pads the final word of a frame whose beat count is not a multiple of `MMV`, and flags that word with `tlast`. Throughput is one input beat per cycle under no back-pressure.

## Interface
- `SIMD`, 1: channels per input beat.
- `IP_PRECISION`, 8: bits per channel element.
- `MMV`, 2: input beats packed per output word; must be ≥1.
- `IFMChannels`, 2: channels per pixel; must be divisible by `SIMD`.
- `IFMWidth`, 8: input feature-map width in pixels.
- `IFMHeight`, 8: input feature-map height in pixels.
- Derived values:
  - `EFF_CHANNELS = IFMChannels/SIMD`
  - `FRAME_BEATS = IFMHeight*IFMWidth*EFF_CHANNELS`
  - `FRAME_WORDS = ceil(FRAME_BEATS/MMV)`

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `ip_axis_tdata`  in  `SIMD*IP_PRECISION`  input beat.
- `ip_axis_tvalid`  in  1  input beat valid.
- `ip_axis_tready`  out  1  packer accepts the beat this cycle.
- `op_axis_tdata`  out  `MMV*SIMD*IP_PRECISION`  packed word; lane 0 is in the LSBs.
- `op_axis_tvalid`  out  1  packed word valid.
- `op_axis_tready`  in  1  downstream accepts the word.
- `op_axis_tlast`  out  1  word contains beat `FRAME_BEATS-1` of the current frame.

## Operation
- Internal state:
  - `lane_cnt`, width `$clog2(MMV)`, minimum 1 bit.
  - `beat_cnt`, width `$clog2(FRAME_BEATS)`, minimum 1 bit.
  - Accumulator `acc`, width `(MMV-1)*SIMD*IP_PRECISION`.
  - Output register: `op_axis_tdata`, `op_axis_tvalid`, `op_axis_tlast`.
- Accepted beat: `ip_axis_tvalid && ip_axis_tready`.
- A beat is *completing* when `lane_cnt==MMV-1` or `beat_cnt==FRAME_BEATS-1`.
- Non-completing accepted beat:
  - Written into lane `lane_cnt` of `acc`.
  - `lane_cnt` increments and `beat_cnt` increments.
- Completing accepted beat:
  - The output register loads `acc`, with the current beat placed in lane `lane_cnt`.
  - Lanes above `lane_cnt` load 0.
  - `op_axis_tvalid<=1`.
  - `op_axis_tlast<=(beat_cnt==FRAME_BEATS-1)`.
  - `acc` clears to 0 and `lane_cnt` goes to 0.
  - `beat_cnt` goes to 0 if this is the last beat of the frame, otherwise it increments.
- `ip_axis_tready = !completing || !op_axis_tvalid || op_axis_tready`. This is combinational.
  - Non-completing beats are never stalled.
  - A completing beat stalls only while a held word is not being drained.
- Output drain: when `op_axis_tvalid && op_axis_tready` with no simultaneous load, `op_axis_tvalid<=0` and `op_axis_tlast<=0`. `op_axis_tdata` holds its last value.
- Simultaneous drain and load in the same cycle: the new word replaces the old one and `op_axis_tvalid` stays 1. There is no bubble.
- The next frame begins immediately after a completing last beat. There is no idle state or inter-frame gap.
- `MMV==1`: every beat is completing, and the block behaves as a one-deep register slice with `tlast`.
- Output stability: while `op_axis_tvalid` is high and `op_axis_tready` is low, `op_axis_tdata` and `op_axis_tlast` must not change.

## Timing
- Reset: while `resetn` is low, the following are 0 immediately (asynchronous):
  - `lane_cnt`, `beat_cnt`, `acc`
  - `op_axis_tdata`, `op_axis_tvalid`, `op_axis_tlast`
- `ip_axis_tready` is 1 while in reset and on the first cycle after release.
- Latency: a word is valid in the cycle after its completing beat is accepted.
- Sustained rate: one word per `MMV` cycles, with the input never stalled, provided `op_axis_tready` stays high.
- Reset mid-frame discards the partial `acc` and any held word. The first beat after release is treated as beat 0 of a new frame.
- Upstream and downstream must follow AXI-stream rules: once a valid is asserted, it and the data stay stable until accepted.

## Test plan
- Basic frame: `SIMD=1`, `IP_PRECISION=8`, `MMV=2`, `IFMChannels=2`, 3x3 map.
  - Stimulus: beats 0x00..0x11 streamed with `op_axis_tready=1`.
  - Response: exactly 9 words 0x0100, 0x0302, …, 0x1110; `tlast` only on 0x1110; `ip_axis_tready` constantly 1.
- Padding: `MMV=2`, `IFMChannels=1`, 3x3 map.
  - Stimulus: beats 0x01..0x09.
  - Response: 5 words; the last is 0x0009 with `tlast=1`.
  - A second frame follows immediately, and its first word is 0x0201.
- Back-pressure: hold `op_axis_tready=0` for 5 cycles after the first word.
  - Response: `ip_axis_tready` drops only when the next completing beat is presented; the word stays stable.
  - On release: the held word drains and the new word loads in the same cycle; no beat is lost or duplicated.
- Random `ip_axis_tvalid` and `op_axis_tready` (50%) over 3 frames with `MMV=4`, `SIMD=2`.
  - Response: scoreboard matches the reference packing and `tlast` count equals 3.
- Reset mid-frame: assert `resetn=0` after beat 5 of a frame.
  - Response: outputs are 0 during reset with no clock edge needed.
  - The next accepted beat appears in lane 0 of the first word, and `tlast` appears after `FRAME_BEATS` further beats.
